// File: rtl/picomips_pkg.sv
// Shared picoMIPS definitions: opcode, ALU-function and loader state encodings.
// Latency: none (types and constants only).
// Backpressure: not applicable.
// Used by the program loader (encode side) and by the decoder (decode side),
// so opcode values here are the single source of truth for the ISA encoding.
package picomips_pkg;

  localparam int OPCODE_W = 3;

  typedef enum logic [OPCODE_W-1:0] {
    ADD  = 3'b000,
    ADDI = 3'b001,
    SUB  = 3'b010,
    SUBI = 3'b011,
    NOP  = 3'b100,
    BRI  = 3'b101,
    MUL  = 3'b110,
    MULI = 3'b111
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_MUL = 2'b10,
    ALU_BRA = 2'b11
  } alufunc_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    DONE = 2'b10,
    ERR  = 2'b11
  } state_t;

endpackage

// File: rtl/picomips_prog_loader_if.sv
// Control-tuple channel from the host/test port into the program loader.
// Latency: none (wires only).
// Backpressure: valid/ready; a tuple moves on a cycle with in_valid && in_ready.
// Ports: in_valid/in_ready handshake, tuple fields alufunc/imm/write/rd/rs/immval/last.
// master = host side (drives the tuple), slave = loader side (drives in_ready).
interface picomips_prog_loader_if #(
  parameter int REG_W = 3,
  parameter int IMM_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_alufunc;
  logic             in_imm;
  logic             in_write;
  logic [REG_W-1:0] in_rd;
  logic [REG_W-1:0] in_rs;
  logic [IMM_W-1:0] in_immval;
  logic             in_last;

  modport master (
    output in_valid, in_alufunc, in_imm, in_write, in_rd, in_rs, in_immval, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_alufunc, in_imm, in_write, in_rd, in_rs, in_immval, in_last,
    output in_ready
  );
endinterface

// File: rtl/picomips_op_encoder.sv
// Maps a control tuple {alufunc, imm, write} onto its picoMIPS opcode.
// Latency: purely combinational.
// Backpressure: none; legal=0 flags a tuple with no opcode (opcode output is then NOP).
// Ports: alufunc/imm/write in, opcode/legal out.
module picomips_op_encoder
  import picomips_pkg::*;
(
  input  alufunc_t alufunc,
  input  logic     imm,
  input  logic     write,
  output opcode_t  opcode,
  output logic     legal
);

  always_comb begin
    opcode = NOP;
    legal  = 1'b1;
    case ({alufunc, imm, write})
      {ALU_ADD, 2'b01}: opcode = ADD;
      {ALU_ADD, 2'b11}: opcode = ADDI;
      {ALU_SUB, 2'b01}: opcode = SUB;
      {ALU_SUB, 2'b11}: opcode = SUBI;
      {ALU_ADD, 2'b00}: opcode = NOP;
      {ALU_BRA, 2'b10}: opcode = BRI;
      {ALU_MUL, 2'b01}: opcode = MUL;
      {ALU_MUL, 2'b11}: opcode = MULI;
      default:          legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/picomips_prog_loader.sv
// Encodes control tuples to picoMIPS instructions and writes them sequentially into instruction memory.
// Latency: a tuple accepted in cycle N is written (mem_we pulse) in cycle N+1.
// Backpressure: in_ready is high only while loading; DONE/ERR/IDLE refuse tuples until start.
// Ports: clk, reset (sync, active-high), start pulse, in_if tuple channel (slave),
//        mem_we/mem_addr/mem_wdata write port, busy/done/err status levels, count of words written.
module picomips_prog_loader
  import picomips_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int REG_W  = 3,
  parameter int IMM_W  = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  picomips_prog_loader_if.slave       in_if,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [2+2*REG_W+IMM_W:0]    mem_wdata,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [ADDR_W:0]             count
);

  localparam int IW = 3 + 2*REG_W + IMM_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [IW-1:0]     mem_wdata_q, mem_wdata_d;

  opcode_t           opcode;
  logic              legal;
  logic              xfer;
  logic [REG_W-1:0]  rd_f, rs_f;
  logic [IMM_W-1:0]  imm_f;
  logic [IW-1:0]     word;

  picomips_op_encoder u_enc (
    .alufunc (alufunc_t'(in_if.in_alufunc)),
    .imm     (in_if.in_imm),
    .write   (in_if.in_write),
    .opcode  (opcode),
    .legal   (legal)
  );

  assign in_if.in_ready = (state_q == LOAD);
  assign xfer           = in_if.in_valid && in_if.in_ready;

  // Register-form instructions carry no immediate, and NOP carries no operands
  // at all, so those fields are zeroed to keep the program image canonical.
  always_comb begin
    rd_f  = in_if.in_rd;
    rs_f  = in_if.in_rs;
    imm_f = in_if.in_imm ? in_if.in_immval : '0;
    if (opcode == NOP) begin
      rd_f  = '0;
      rs_f  = '0;
      imm_f = '0;
    end
    word = {opcode, rd_f, rs_f, imm_f};
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    count_d     = count_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      LOAD: begin
        if (start) begin
          // Restart wins over any tuple offered in the same cycle.
          ptr_d   = '0;
          count_d = '0;
        end else if (xfer) begin
          if (!legal) begin
            state_d = ERR;
          end else begin
            mem_we_d    = 1'b1;
            mem_addr_d  = ptr_q;
            mem_wdata_d = word;
            count_d     = count_q + 1'b1;
            // The pointer parks on the last address instead of wrapping;
            // the load is over once that slot is written.
            if (ptr_q == LAST_ADDR || in_if.in_last) begin
              state_d = DONE;
            end
            if (ptr_q != LAST_ADDR) begin
              ptr_d = ptr_q + 1'b1;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d = LOAD;
          ptr_d   = '0;
          count_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      count_q     <= count_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == LOAD);
  assign done      = (state_q == DONE);
  assign err       = (state_q == ERR);
  assign count     = count_q;

endmodule

// File: tb/tb_picomips_prog_loader.sv
module tb_picomips_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [16:0] mem_wdata;
  logic        busy, done, err;
  logic [6:0]  count;

  int total = 0;
  int bad   = 0;

  picomips_prog_loader_if #(.REG_W(3), .IMM_W(8)) bus ();

  picomips_prog_loader #(.ADDR_W(6), .REG_W(3), .IMM_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .in_if     (bus),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Reference model: legal tuples {alufunc,imm,write} indexed by opcode value.
  logic [3:0] ENC [8] = '{4'b0001, 4'b0011, 4'b0101, 4'b0111,
                          4'b0000, 4'b1110, 4'b1001, 4'b1011};
  localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2, M_ERR = 3;
  int m_state = M_IDLE;
  int m_cnt   = 0;       // words written this load; also the next write address
  logic [22:0] exp_q[$]; // {addr, word}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lookup(input logic [3:0] t);
    for (int i = 0; i < 8; i++) if (ENC[i] == t) return i;
    return -1;
  endfunction

  function automatic logic [16:0] model_word(input int op, input logic i, input logic [2:0] rd,
                                             input logic [2:0] rs, input logic [7:0] iv);
    int w;
    if (op == 4) w = 4 * 16384;
    else w = op * 16384 + int'(rd) * 2048 + int'(rs) * 256 + (i ? int'(iv) : 0);
    return w[16:0];
  endfunction

  // One clock cycle of stimulus; the model is advanced with the same inputs.
  task automatic cyc(input bit r, input bit s, input bit v, input logic [3:0] t,
                     input logic [2:0] rd, input logic [2:0] rs, input logic [7:0] iv, input bit l);
    int op;
    logic [5:0] a;
    reset = r; start = s;
    bus.in_valid = v; bus.in_alufunc = t[3:2]; bus.in_imm = t[1]; bus.in_write = t[0];
    bus.in_rd = rd; bus.in_rs = rs; bus.in_immval = iv; bus.in_last = l;
    if (r) begin
      m_state = M_IDLE; m_cnt = 0;
    end else if (m_state == M_LOAD) begin
      if (s) m_cnt = 0;
      else if (v) begin
        op = lookup(t);
        if (op < 0) m_state = M_ERR;
        else begin
          a = m_cnt[5:0];
          exp_q.push_back({a, model_word(op, t[1], rd, rs, iv)});
          m_cnt++;
          if (l || m_cnt == 64) m_state = M_DONE;
        end
      end
    end else if (s) begin
      m_state = M_LOAD; m_cnt = 0;
    end
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
  endtask

  task automatic send(input int op, input logic [2:0] rd, input logic [2:0] rs,
                      input logic [7:0] iv, input bit l);
    cyc(0, 0, 1, ENC[op], rd, rs, iv, l);
  endtask

  task automatic chk_status(input string tag);
    chk({tag, " in_ready"}, 32'(bus.in_ready), 32'(m_state == M_LOAD));
    chk({tag, " busy"},     32'(busy),         32'(m_state == M_LOAD));
    chk({tag, " done"},     32'(done),         32'(m_state == M_DONE));
    chk({tag, " err"},      32'(err),          32'(m_state == M_ERR));
    chk({tag, " count"},    32'(count),        32'(m_cnt));
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected write: addr %0h data %0h, none expected", mem_addr, mem_wdata);
      end else begin
        logic [22:0] e;
        e = exp_q.pop_front();
        chk("write addr", 32'(mem_addr), 32'(e[22:17]));
        chk("write data", 32'(mem_wdata), 32'(e[16:0]));
      end
    end
  end

  initial begin
    logic [3:0] t;
    bus.in_valid = 0; bus.in_alufunc = 0; bus.in_imm = 0; bus.in_write = 0;
    bus.in_rd = 0; bus.in_rs = 0; bus.in_immval = 0; bus.in_last = 0;
    cyc(1, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);   // start together with reset: reset wins
    cyc(1, 0, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    chk("reset mem_we", 32'(mem_we), 0);
    chk("reset mem_addr", 32'(mem_addr), 0);
    chk("reset mem_wdata", 32'(mem_wdata), 0);
    chk_status("reset");

    // Basic three-instruction program.
    cyc(0, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    chk_status("started");
    send(0, 3'd1, 3'd2, 8'h00, 0);   // ADD  r1,r2
    send(1, 3'd1, 3'd0, 8'h05, 0);   // ADDI r1,5
    send(6, 3'd3, 3'd1, 8'h00, 1);   // MUL  r3,r1, last
    idle(2);
    chk_status("prog3");

    // Field forcing: register-form immediate and NOP operands zeroed.
    cyc(0, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    send(0, 3'd2, 3'd3, 8'hFF, 0);
    send(4, 3'd5, 3'd6, 8'hA5, 1);
    idle(2);
    chk_status("forcing");

    // Illegal tuple: no write, ERR, count holds; start recovers.
    cyc(0, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    send(2, 3'd1, 3'd1, 8'h00, 0);
    cyc(0, 0, 1, 4'b1101, 3'd4, 3'd4, 8'h11, 0);
    idle(2);
    chk_status("illegal");
    cyc(0, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    chk_status("restart after err");

    // Fill the whole memory without in_last.
    for (int k = 0; k < 1000 && m_state == M_LOAD; k++)
      cyc(0, 0, ($urandom_range(0, 3) != 0), ENC[$urandom_range(0, 7)],
          3'($urandom), 3'($urandom), 8'($urandom), 0);
    chk("full reached", 32'(m_state), M_DONE);
    send(0, 3'd1, 3'd1, 8'h00, 0);   // refused: not loading
    idle(2);
    chk_status("full");

    // start colliding with a transfer at pointer 4.
    cyc(0, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    for (int k = 0; k < 4; k++) send(3, 3'(k), 3'd7, 8'(k * 17), 0);
    cyc(0, 1, 1, ENC[0], 3'd6, 3'd6, 8'd0, 0);
    chk_status("start collides");
    send(7, 3'd2, 3'd4, 8'h3C, 0);
    idle(2);
    chk_status("after collide");

    // Reset: in the cycle after a transfer, and coinciding with one.
    send(5, 3'd1, 3'd2, 8'h80, 0);
    cyc(1, 0, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    chk("post-reset mem_we", 32'(mem_we), 0);
    chk("post-reset mem_addr", 32'(mem_addr), 0);
    chk("post-reset mem_wdata", 32'(mem_wdata), 0);
    chk_status("post-reset");
    idle(2);
    chk_status("idle after reset");
    cyc(0, 1, 0, 4'b0, 3'd0, 3'd0, 8'd0, 0);
    cyc(1, 0, 1, ENC[1], 3'd3, 3'd3, 8'h44, 0);
    idle(2);
    chk_status("reset with transfer");

    // Random mixed traffic, status compared every cycle.
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) == 0) t = 4'($urandom);
      else t = ENC[$urandom_range(0, 7)];
      cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) != 0),
          t, 3'($urandom), 3'($urandom), 8'($urandom), ($urandom_range(0, 15) == 0));
      chk_status("random");
    end

    idle(3);
    chk("pending writes", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
